// File: rtl/gpio_pkg.sv
// Shared definitions for the AHB-Lite GPIO with edge interrupts.
//
// Contents:
//   reg_idx_t          3-bit register index, taken from HADDR[4:2]
//   ADDR_*             register indices (byte offset = index * 4)
//   HTRANS_*           AHB-Lite transfer type encodings
//
// Optional build macro used by the GPIO files: GPIO_DEBOUNCE_EN
package gpio_pkg;

    typedef logic [2:0] reg_idx_t;

    // Register indices. Indices 6 and 7 (0x18, 0x1C) are unmapped.
    localparam reg_idx_t ADDR_DOUT     = 3'd0;  // 0x00
    localparam reg_idx_t ADDR_DIN      = 3'd1;  // 0x04
    localparam reg_idx_t ADDR_DIR      = 3'd2;  // 0x08
    localparam reg_idx_t ADDR_RISE_EN  = 3'd3;  // 0x0C
    localparam reg_idx_t ADDR_FALL_EN  = 3'd4;  // 0x10
    localparam reg_idx_t ADDR_IRQ_STAT = 3'd5;  // 0x14

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

endpackage

// File: rtl/gpio_in_cond.sv
// GPIO input conditioning: 2-flop synchroniser, optional per-bit debounce
// filter and rising/falling edge detection on the filtered value.
//
// Ports:
//   clk      system clock
//   rst      asynchronous active-high reset (clears all history)
//   gpio_in  asynchronous pin inputs
//   din      filtered synchronised pin value
//   rise     1 where din went 0->1 relative to the previous cycle
//   fall     1 where din went 1->0 relative to the previous cycle
//
// Build macro GPIO_DEBOUNCE_EN: when defined, din[i] follows the
// synchronised input only after it has held a new value for
// DEBOUNCE_CYCLES consecutive cycles; otherwise din is the synchroniser
// output and DEBOUNCE_CYCLES has no effect.
module gpio_in_cond
    import gpio_pkg::*;
#(
    parameter int GPIO_W          = 16,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [GPIO_W-1:0] gpio_in,
    output logic [GPIO_W-1:0] din,
    output logic [GPIO_W-1:0] rise,
    output logic [GPIO_W-1:0] fall
);

    logic [GPIO_W-1:0] sync1;
    logic [GPIO_W-1:0] sync2;
    logic [GPIO_W-1:0] filt;
    logic [GPIO_W-1:0] prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
            prev  <= '0;
        end else begin
            sync1 <= gpio_in;
            sync2 <= sync1;
            prev  <= filt;
        end
    end

`ifdef GPIO_DEBOUNCE_EN
    // Counter reaches DEBOUNCE_CYCLES-1 on the last of the required stable
    // cycles; the filtered bit is updated on that same edge.
    localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE_CYCLES - 1);

    logic [7:0] cnt [GPIO_W];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            filt <= '0;
            for (int i = 0; i < GPIO_W; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < GPIO_W; i++) begin
                if (sync2[i] == filt[i]) begin
                    // Input agrees with the filtered value: any bounce
                    // restarts the count.
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    filt[i] <= sync2[i];
                    cnt[i]  <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 8'd1;
                end
            end
        end
    end
`else
    localparam int unused_debounce_cycles = DEBOUNCE_CYCLES;

    assign filt = sync2;
`endif

    assign din  = filt;
    assign rise = filt & ~prev;
    assign fall = ~filt & prev;

endmodule

// File: rtl/ahb_gpio_irq.sv
// AHB-Lite slave GPIO with per-bit direction, synchronised input and
// rising/falling edge interrupts (write-1-to-clear status, one combined
// registered interrupt line).
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   HSEL, HADDR, HTRANS,     AHB-Lite address phase; only HADDR[4:2] is
//   HWRITE, HREADY           decoded
//   HWDATA                   write data (data phase)
//   HREADYOUT                always 1, zero wait states
//   HRDATA                   read data, 0 outside a read data phase
//   GPIOIN                   asynchronous pin inputs
//   GPIOOUT, GPIOOE          output data and per-bit output enable
//   GPIOIRQ                  registered OR of pending status bits
//
// Register map (byte offset): 0x00 DOUT RW, 0x04 DIN RO, 0x08 DIR RW,
// 0x0C RISE_EN RW, 0x10 FALL_EN RW, 0x14 IRQ_STAT W1C, 0x18/0x1C read 0.
//
// Build macro GPIO_DEBOUNCE_EN enables the input debounce filter inside
// gpio_in_cond.
//
// Handshake: an address phase is taken when HSEL & HREADY & HTRANS[1] are
// all 1 at a rising edge; its data phase is the following cycle, in which
// HWDATA is written at the next edge or HRDATA is driven combinationally.
// HREADYOUT is constantly 1, so no transfer is ever stretched.
module ahb_gpio_irq
    import gpio_pkg::*;
#(
    parameter int GPIO_W          = 16,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              HSEL,
    input  logic [31:0]       HADDR,
    input  logic [1:0]        HTRANS,
    input  logic              HWRITE,
    input  logic [31:0]       HWDATA,
    input  logic              HREADY,
    output logic              HREADYOUT,
    output logic [31:0]       HRDATA,
    input  logic [GPIO_W-1:0] GPIOIN,
    output logic [GPIO_W-1:0] GPIOOUT,
    output logic [GPIO_W-1:0] GPIOOE,
    output logic              GPIOIRQ
);

    logic     dp_valid;
    logic     dp_write;
    reg_idx_t dp_idx;

    logic [GPIO_W-1:0] dout;
    logic [GPIO_W-1:0] dir;
    logic [GPIO_W-1:0] rise_en;
    logic [GPIO_W-1:0] fall_en;
    logic [GPIO_W-1:0] stat;
    logic              irq_q;

    logic [GPIO_W-1:0] din;
    logic [GPIO_W-1:0] rise;
    logic [GPIO_W-1:0] fall;

    logic              accept;
    logic              wr_en;
    logic [GPIO_W-1:0] wdata;
    logic [GPIO_W-1:0] w1c;
    logic [GPIO_W-1:0] stat_set;
    logic [GPIO_W-1:0] rd_sel;

    // Address bits outside [4:2], HTRANS[0] and upper write-data bits carry
    // no meaning for this slave.
    logic unused_bus_bits;
    assign unused_bus_bits = ^{HADDR[31:5], HADDR[1:0], HTRANS[0], HWDATA};

    gpio_in_cond #(
        .GPIO_W          (GPIO_W),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_in_cond (
        .clk     (clk),
        .rst     (rst),
        .gpio_in (GPIOIN),
        .din     (din),
        .rise    (rise),
        .fall    (fall)
    );

    assign accept = HSEL & HREADY & HTRANS[1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dp_valid <= 1'b0;
            dp_write <= 1'b0;
            dp_idx   <= ADDR_DOUT;
        end else begin
            dp_valid <= accept;
            if (accept) begin
                dp_write <= HWRITE;
                dp_idx   <= HADDR[4:2];
            end
        end
    end

    assign wr_en    = dp_valid & dp_write;
    assign wdata    = HWDATA[GPIO_W-1:0];
    assign w1c      = (wr_en && (dp_idx == ADDR_IRQ_STAT)) ? wdata : '0;
    assign stat_set = (rise & rise_en) | (fall & fall_en);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout    <= '0;
            dir     <= '0;
            rise_en <= '0;
            fall_en <= '0;
            stat    <= '0;
            irq_q   <= 1'b0;
        end else begin
            if (wr_en) begin
                case (dp_idx)
                    ADDR_DOUT:    dout    <= wdata;
                    ADDR_DIR:     dir     <= wdata;
                    ADDR_RISE_EN: rise_en <= wdata;
                    ADDR_FALL_EN: fall_en <= wdata;
                    default:      ;
                endcase
            end
            // Set is applied after the clear so a coincident edge wins.
            stat  <= (stat & ~w1c) | stat_set;
            irq_q <= |stat;
        end
    end

    always_comb begin
        rd_sel = '0;
        if (dp_valid && !dp_write) begin
            case (dp_idx)
                ADDR_DOUT:     rd_sel = dout;
                ADDR_DIN:      rd_sel = din;
                ADDR_DIR:      rd_sel = dir;
                ADDR_RISE_EN:  rd_sel = rise_en;
                ADDR_FALL_EN:  rd_sel = fall_en;
                ADDR_IRQ_STAT: rd_sel = stat;
                default:       rd_sel = '0;
            endcase
        end
    end

    // Zero-extend without a replication that would be empty at GPIO_W=32.
    always_comb begin
        HRDATA = '0;
        HRDATA[GPIO_W-1:0] = rd_sel;
    end

    assign HREADYOUT = 1'b1;
    assign GPIOOUT   = dout;
    assign GPIOOE    = dir;
    assign GPIOIRQ   = irq_q;

endmodule

// File: tb/tb_ahb_gpio_irq.sv
module tb_ahb_gpio_irq;
    import gpio_pkg::*;

    localparam int          W    = 16;
    localparam logic [31:0] MASK = 32'h0000_FFFF;

    logic          clk;
    logic          rst;
    logic          HSEL;
    logic [31:0]   HADDR;
    logic [1:0]    HTRANS;
    logic          HWRITE;
    logic [31:0]   HWDATA;
    logic          HREADY;
    logic          HREADYOUT;
    logic [31:0]   HRDATA;
    logic [W-1:0]  GPIOIN;
    logic [W-1:0]  GPIOOUT;
    logic [W-1:0]  GPIOOE;
    logic          GPIOIRQ;

    ahb_gpio_irq #(.GPIO_W(W), .DEBOUNCE_CYCLES(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .HSEL      (HSEL),
        .HADDR     (HADDR),
        .HTRANS    (HTRANS),
        .HWRITE    (HWRITE),
        .HWDATA    (HWDATA),
        .HREADY    (HREADY),
        .HREADYOUT (HREADYOUT),
        .HRDATA    (HRDATA),
        .GPIOIN    (GPIOIN),
        .GPIOOUT   (GPIOOUT),
        .GPIOOE    (GPIOOE),
        .GPIOIRQ   (GPIOIRQ)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    int total = 0;
    int bad   = 0;
    logic [31:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // ---------------- driver tasks (all start/end at posedge+1) ----------------
    task automatic idle_bus();
        HSEL   = 1'b0;
        HTRANS = HTRANS_IDLE;
        HWRITE = 1'b0;
    endtask

    task automatic addr_phase(input logic [31:0] a, input logic w);
        HSEL   = 1'b1;
        HTRANS = HTRANS_NONSEQ;
        HADDR  = a;
        HWRITE = w;
        HREADY = 1'b1;
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        addr_phase(a, 1'b1);
        wait_cyc(1);
        HWDATA = d;
        idle_bus();
        wait_cyc(1);
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        addr_phase(a, 1'b0);
        wait_cyc(1);
        idle_bus();
        d = HRDATA;
        chk("hreadyout", {31'd0, HREADYOUT}, 32'd1);
        wait_cyc(1);
    endtask

    task automatic rd_check(input string name, input logic [31:0] a);
        logic [31:0] d;
        bus_read(a, d);
        chk(name, d, exp_q.pop_front());
    endtask

    // ---------------- vector table ----------------
    typedef struct packed {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] exp;
    } vec_t;

    vec_t vq[$];

    task automatic add_vec(input logic wr, input logic [31:0] a, input logic [31:0] d,
                           input logic [31:0] e);
        vq.push_back('{wr, a, d, e});
    endtask

    // Reference model for edge interrupts: status accumulates every
    // enabled 0->1 / 1->0 transition in the sequence of pin values seen.
    function automatic logic [31:0] edges(input logic [31:0] from, input logic [31:0] to,
                                          input logic [31:0] re, input logic [31:0] fe);
        return ((to & ~from & re) | (~to & from & fe)) & MASK;
    endfunction

    initial begin
        logic [31:0] d;
        logic [31:0] exp_stat;
        logic [31:0] last_pin;
        logic [31:0] prev_pin;
        logic [31:0] v;
        logic [31:0] re;
        logic [31:0] fe;
        logic [31:0] m;
        int          n;

        rst    = 1'b1;
        HSEL   = 1'b0;
        HADDR  = '0;
        HTRANS = HTRANS_IDLE;
        HWRITE = 1'b0;
        HWDATA = '0;
        HREADY = 1'b1;
        GPIOIN = '0;
        wait_cyc(3);
        chk("rst_gpioout", 32'(GPIOOUT), 32'd0);
        chk("rst_gpiooe", 32'(GPIOOE), 32'd0);
        chk("rst_irq", {31'd0, GPIOIRQ}, 32'd0);
        chk("rst_hrdata", HRDATA, 32'd0);
        rst = 1'b0;
        wait_cyc(1);

        // ---- register table ----
        for (int a = 0; a < 8; a++) add_vec(1'b0, 32'(a * 4), 32'd0, 32'd0);
        add_vec(1'b1, 32'h00, 32'h0000_A5A5, 32'd0);
        add_vec(1'b1, 32'h08, 32'h0000_00FF, 32'd0);
        add_vec(1'b0, 32'h00, 32'd0, 32'h0000_A5A5);
        add_vec(1'b0, 32'h08, 32'd0, 32'h0000_00FF);
        add_vec(1'b1, 32'h00, 32'hFFFF_1234, 32'd0);
        add_vec(1'b0, 32'h00, 32'd0, 32'h0000_1234);
        add_vec(1'b1, 32'h04, 32'h0000_FFFF, 32'd0);
        add_vec(1'b0, 32'h04, 32'd0, 32'd0);
        add_vec(1'b1, 32'h0C, 32'hFFFF_FFFF, 32'd0);
        add_vec(1'b0, 32'h0C, 32'd0, 32'h0000_FFFF);
        add_vec(1'b1, 32'h10, 32'h0000_ABCD, 32'd0);
        add_vec(1'b0, 32'h10, 32'd0, 32'h0000_ABCD);
        add_vec(1'b1, 32'h18, 32'h0000_FFFF, 32'd0);
        add_vec(1'b0, 32'h18, 32'd0, 32'd0);
        add_vec(1'b1, 32'h1C, 32'h0000_0001, 32'd0);
        add_vec(1'b0, 32'h1C, 32'd0, 32'd0);
        add_vec(1'b0, 32'h14, 32'd0, 32'd0);
        add_vec(1'b1, 32'h0C, 32'd0, 32'd0);
        add_vec(1'b1, 32'h10, 32'd0, 32'd0);
        add_vec(1'b0, 32'h0C, 32'd0, 32'd0);

        for (int i = 0; i < vq.size(); i++) begin
            if (vq[i].wr) begin
                bus_write(vq[i].addr, vq[i].data);
            end else begin
                exp_q.push_back(vq[i].exp);
                rd_check($sformatf("vec%0d_a%02h", i, vq[i].addr[7:0]), vq[i].addr);
            end
        end
        chk("gpioout_1234", 32'(GPIOOUT), 32'h0000_1234);
        chk("gpiooe_00ff", 32'(GPIOOE), 32'h0000_00FF);

        // ---- back-to-back write then read of the same register ----
        addr_phase(32'h08, 1'b1);
        wait_cyc(1);
        HWDATA = 32'h0000_0F0F;
        addr_phase(32'h08, 1'b0);
        wait_cyc(1);
        idle_bus();
        chk("wr_rd_b2b", HRDATA, 32'h0000_0F0F);
        wait_cyc(1);
        chk("hrdata_idle", HRDATA, 32'd0);
        chk("gpiooe_0f0f", 32'(GPIOOE), 32'h0000_0F0F);

`ifndef GPIO_DEBOUNCE_EN
        // ---- DIN latency: pin sampled at E1 visible after E2 ----
        GPIOIN = 16'h8001;
        addr_phase(32'h04, 1'b0);
        wait_cyc(1);
        chk("din_lat1", HRDATA, 32'd0);
        wait_cyc(1);
        chk("din_lat2", HRDATA, 32'h0000_8001);
        idle_bus();
        wait_cyc(1);
        exp_q.push_back(32'd0);
        rd_check("stat_no_en", 32'h14);
        chk("irq_no_en", {31'd0, GPIOIRQ}, 32'd0);

        // ---- rise on bit 0, fall on bit 15 ----
        GPIOIN = 16'h8000;
        wait_cyc(4);
        bus_write(32'h0C, 32'h0000_0001);
        bus_write(32'h10, 32'h0000_8000);
        GPIOIN = 16'h0001;
        wait_cyc(3);
        chk("irq_pre", {31'd0, GPIOIRQ}, 32'd0);
        wait_cyc(1);
        chk("irq_set", {31'd0, GPIOIRQ}, 32'd1);
        exp_q.push_back(32'h0000_8001);
        rd_check("stat_8001", 32'h14);
        bus_write(32'h14, 32'h0000_0001);
        exp_q.push_back(32'h0000_8000);
        rd_check("stat_8000", 32'h14);
        chk("irq_still", {31'd0, GPIOIRQ}, 32'd1);
        bus_write(32'h14, 32'h0000_8000);
        chk("irq_lag", {31'd0, GPIOIRQ}, 32'd1);
        wait_cyc(1);
        chk("irq_clear", {31'd0, GPIOIRQ}, 32'd0);

        // ---- rising edge coincident with W1C of the same bit ----
        GPIOIN = 16'h0000;
        wait_cyc(4);
        GPIOIN = 16'h0001;
        wait_cyc(1);
        addr_phase(32'h14, 1'b1);
        wait_cyc(1);
        HWDATA = 32'h0000_0001;
        idle_bus();
        wait_cyc(1);
        exp_q.push_back(32'h0000_0001);
        rd_check("set_beats_clr", 32'h14);

        // ---- reset in the middle of a write data phase ----
        addr_phase(32'h00, 1'b1);
        wait_cyc(1);
        HWDATA = 32'h0000_FFFF;
        idle_bus();
        rst = 1'b1;
        #1;
        chk("mid_rst_gpioout", 32'(GPIOOUT), 32'd0);
        chk("mid_rst_gpiooe", 32'(GPIOOE), 32'd0);
        chk("mid_rst_irq", {31'd0, GPIOIRQ}, 32'd0);
        chk("mid_rst_hrdata", HRDATA, 32'd0);
        chk("mid_rst_hready", {31'd0, HREADYOUT}, 32'd1);
        #1;
        rst = 1'b0;
        wait_cyc(1);
        exp_q.push_back(32'd0);
        rd_check("dropped_write", 32'h00);
        exp_q.push_back(32'd0);
        rd_check("stat_after_rst", 32'h14);

        // ---- randomized edge sequences against the model ----
        wait_cyc(4);
        last_pin = 32'(GPIOIN);
        for (int it = 0; it < 20; it++) begin
            re = $urandom & MASK;
            fe = $urandom & MASK;
            bus_write(32'h0C, re);
            bus_write(32'h10, fe);
            bus_write(32'h14, 32'hFFFF_FFFF);
            exp_stat = '0;
            prev_pin = last_pin;
            n = $urandom_range(1, 6);
            for (int j = 0; j < n; j++) begin
                v = $urandom & MASK;
                GPIOIN = v[W-1:0];
                exp_stat |= edges(prev_pin, v, re, fe);
                prev_pin = v;
                wait_cyc(1);
            end
            last_pin = prev_pin;
            wait_cyc(5);
            exp_q.push_back(exp_stat);
            rd_check($sformatf("rnd%0d_stat", it), 32'h14);
            exp_q.push_back(last_pin);
            rd_check($sformatf("rnd%0d_din", it), 32'h04);
            chk($sformatf("rnd%0d_irq", it), {31'd0, GPIOIRQ}, {31'd0, |exp_stat});
            m = $urandom & MASK;
            bus_write(32'h14, m);
            exp_stat &= ~m;
            exp_q.push_back(exp_stat);
            rd_check($sformatf("rnd%0d_w1c", it), 32'h14);
            chk($sformatf("rnd%0d_irq_w1c", it), {31'd0, GPIOIRQ}, {31'd0, |exp_stat});
        end
`else
        // ---- debounce: 3-cycle glitch rejected, 4-cycle hold accepted ----
        bus_write(32'h0C, 32'h0000_0008);
        GPIOIN = 16'h0008;
        wait_cyc(3);
        GPIOIN = 16'h0000;
        wait_cyc(10);
        exp_q.push_back(32'd0);
        rd_check("glitch_din", 32'h04);
        exp_q.push_back(32'd0);
        rd_check("glitch_stat", 32'h14);
        chk("glitch_irq", {31'd0, GPIOIRQ}, 32'd0);
        GPIOIN = 16'h0008;
        wait_cyc(4);
        addr_phase(32'h04, 1'b0);
        wait_cyc(1);
        chk("db_din_c5", HRDATA, 32'd0);
        wait_cyc(1);
        chk("db_din_c6", HRDATA, 32'h0000_0008);
        idle_bus();
        wait_cyc(3);
        exp_q.push_back(32'h0000_0008);
        rd_check("db_stat", 32'h14);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ahb_gpio_irq.md
Name: ahb_gpio_irq

Overview:
AHB-Lite slave GPIO, the parametrised successor to the fixed 16-bit AHB GPIO. It adds configurable width, a per-bit direction register and a synchronised input path. It also adds per-bit rising/falling edge interrupt detection with a write-1-to-clear status register and a single combined interrupt output. It sits on the AHB-Lite bus behind the address decoder, alongside the other AHB peripherals.

Parameters:
GPIO_W, 16, number of GPIO bits; legal range 1..32; register bits [31:GPIO_W] read 0, writes to them ignored
DEBOUNCE_CYCLES, 4, stable-cycle count for the input filter; used only when GPIO_DEBOUNCE_EN is defined; legal range 2..255

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  asynchronous active-high reset
HSEL  in  1  slave select
HADDR  in  32  byte address; only [4:2] decoded
HTRANS  in  2  transfer type; HTRANS[1]=1 means NONSEQ/SEQ
HWRITE  in  1  1=write, 0=read
HWDATA  in  32  write data, valid in data phase
HREADY  in  1  bus ready; address phase accepted only when 1
HREADYOUT  out  1  slave ready; tied 1 (zero wait states)
HRDATA  out  32  read data, valid in data phase
GPIOIN  in  GPIO_W  asynchronous pin inputs
GPIOOUT  out  GPIO_W  output data
GPIOOE  out  GPIO_W  output enable per bit (1=drive)
GPIOIRQ  out  1  registered OR of enabled pending status bits

Behaviour:
- Clock and reset: one clock, clk; reset rst is asynchronous, active-high.
- Reset values: all registers 0, GPIOOUT=0, GPIOOE=0, GPIOIRQ=0, HRDATA=0, HREADYOUT=1. The sync/filter/edge history also resets to 0.
- Reset mid-transfer: any pending write is dropped, and the pending status is cleared.
- Address phase is accepted when HSEL & HREADY & HTRANS[1]. On accept, HADDR[4:2] and HWRITE are latched into the data-phase registers with a valid flag. Otherwise the valid flag clears.
- Write: in the data phase, HWDATA updates the addressed register at the next rising edge. Writes are 1-cycle and never stall.
- Read: HRDATA is a combinational mux of the latched address in the data phase. It is 0 when there is no valid read data phase.
- Back-to-back write-then-read to the same register returns the newly written value.
- Register map (byte offset):
  - 0x00 DOUT, RW, drives GPIOOUT.
  - 0x04 DIN, RO, filtered synchronised input.
  - 0x08 DIR, RW, drives GPIOOE.
  - 0x0C RISE_EN, RW.
  - 0x10 FALL_EN, RW.
  - 0x14 IRQ_STAT, W1C.
  - 0x18..0x1C are unmapped: read 0, writes ignored. Writes to DIN are ignored.
- Input path: 2-flop synchroniser on GPIOIN. The optional filter follows. DIN shows a pin change 2 cycles after it is sampled (filter disabled).
- Edge detect compares the filtered value with its value one cycle earlier:
  - rise = now & ~prev;
  - fall = ~now & prev.
- Status set: IRQ_STAT[i] sets when (rise[i] & RISE_EN[i]) | (fall[i] & FALL_EN[i]). It is sticky until cleared by writing 1 to that bit.
- Set vs clear: a set and a W1C in the same cycle on the same bit leaves the bit set.
- Edges on output bits (DIR=1) are still detected; DIN always reflects the pins.
- GPIOIRQ = |IRQ_STAT, registered, so it follows IRQ_STAT by 1 cycle. It deasserts 1 cycle after the last bit is cleared.
- Enable changes: clearing RISE_EN/FALL_EN does not clear already-pending status.

Optional Feature:
GPIO_DEBOUNCE_EN
- Defined: each bit has a counter. The filtered value changes only after the synchronised input has held a new value for DEBOUNCE_CYCLES consecutive cycles. Any bounce restarts the counter. Latency from the pin to DIN becomes 2+DEBOUNCE_CYCLES cycles.
- Not defined: filtered value = synchronised value, no counters are instantiated, and DEBOUNCE_CYCLES is ignored.

Decomposition:
- Package gpio_pkg holds:
  - register offset localparams (ADDR_DOUT..ADDR_IRQ_STAT);
  - a typedef for the 3-bit register index;
  - HTRANS encoding constants (IDLE, BUSY, NONSEQ, SEQ).
- Sub-module gpio_in_cond (parameter GPIO_W) holds the synchroniser, the optional debounce and the edge detect. It outputs din, rise and fall vectors.
- The top module holds the AHB pipeline, the register file and the IRQ logic.

Test Plan:
- Reset then read all of 0x00..0x1C: all return 0x0000_0000, HREADYOUT=1 throughout, GPIOOUT=0, GPIOOE=0, GPIOIRQ=0.
- Write DOUT=0xA5A5 and DIR=0x00FF, then read both back-to-back: reads return 0xA5A5 and 0x00FF; GPIOOUT=0xA5A5, GPIOOE=0x00FF; write 0xFFFF_1234 to DOUT with GPIO_W=16: reads back 0x0000_1234.
- GPIOIN 0x0000→0x8001 (filter off): DIN reads 0x8001 from cycle 2 after the sample edge; nothing pending while RISE_EN=0.
- RISE_EN=0x0001, FALL_EN=0x8000; toggle GPIOIN[0] 0→1 and GPIOIN[15] 1→0: IRQ_STAT=0x8001, GPIOIRQ=1 one cycle later; write 0x0001 to IRQ_STAT → 0x8000, GPIOIRQ stays 1; write 0x8000 → 0, GPIOIRQ=0 next cycle.
- Rising edge on bit 0 in the same cycle as a W1C write of 0x0001: IRQ_STAT[0] remains 1; assert rst mid-transfer: all outputs 0 immediately, and the write completing after reset has no effect.
- GPIO_DEBOUNCE_EN defined, DEBOUNCE_CYCLES=4: glitch GPIOIN[3] high for 3 cycles → DIN[3] stays 0 and no IRQ; hold high for 4+ cycles → DIN[3]=1 at cycle 6 after the pin change.
